// File: rtl/cpu_trap_ctrl.sv
// cpu_trap_ctrl
// Trap sequencer for a supervisor-mode CPU. It takes synchronous exceptions,
// interrupts and sret requests at instruction granularity and turns them into
// a one-cycle exception pulse to the CSR block followed by a held PC redirect
// to fetch.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   exc_* / irq_* / sret     request inputs, sampled only while idle
//   fetch_pc, inst_pc,
//   inst_bits, mem_addr      trap context used to build sepc/stval
//   int_enable               sstatus.SIE
//   inst_boundary            interrupts are only taken between instructions
//   exc_handler_addr         stvec (mode in bits [1:0])
//   exc_continue_addr        sepc, the sret return target
//   exception                one-cycle pulse telling the CSR block to commit
//   exc_cause/pc/value       scause/sepc/stval, held until the next trap
//   flush                    pipeline flush during COMMIT and REDIRECT
//   redirect_valid/pc        PC redirect, held until redirect_ready
//   redirect_ready           fetch accepts the redirect
//   busy                     controller is not idle; requests are ignored
module cpu_trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_fetch_misalign,
  input  logic [31:0] fetch_pc,
  input  logic        exc_illegal,
  input  logic        exc_ecall,
  input  logic        exc_ebreak,
  input  logic        exc_ld_misalign,
  input  logic        exc_st_misalign,
  input  logic [31:0] inst_pc,
  input  logic [31:0] inst_bits,
  input  logic [31:0] mem_addr,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic        int_enable,
  input  logic        inst_boundary,
  input  logic        sret,
  input  logic [31:0] exc_handler_addr,
  input  logic [31:0] exc_continue_addr,
  output logic        exception,
  output logic [31:0] exc_cause,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_value,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    REDIRECT
  } state_t;

  state_t      state, state_nxt;

  logic        trap_take;
  logic [31:0] trap_cause, trap_pc, trap_value;
  logic        capture;
  logic        redirect_load;
  logic [31:0] redirect_nxt;
  logic [31:0] trap_base, trap_target;

  // Request arbitration: synchronous exceptions in fixed priority, then
  // interrupts (external over timer) only at an instruction boundary with
  // interrupts enabled.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    trap_take  = 1'b1;
    trap_cause = 32'd0;
    trap_pc    = inst_pc;
    trap_value = 32'd0;
    if (exc_fetch_misalign) begin
      trap_cause = 32'd0;
      trap_pc    = fetch_pc;
      trap_value = fetch_pc;
    end else if (exc_illegal) begin
      trap_cause = 32'd2;
      trap_value = inst_bits;
    end else if (exc_ebreak) begin
      trap_cause = 32'd3;
      trap_value = inst_pc;
    end else if (exc_ecall) begin
      trap_cause = 32'd9;
    end else if (exc_ld_misalign) begin
      trap_cause = 32'd4;
      trap_value = mem_addr;
    end else if (exc_st_misalign) begin
      trap_cause = 32'd6;
      trap_value = mem_addr;
    end else if (int_enable && inst_boundary && irq_ext) begin
      trap_cause = 32'h8000_0009;
    end else if (int_enable && inst_boundary && irq_timer) begin
      trap_cause = 32'h8000_0005;
    end else begin
      trap_take = 1'b0;
    end
  end

  // Handler address: vectored mode (1) only applies to interrupts; the
  // 32-bit add wraps naturally.
  assign trap_base   = {exc_handler_addr[31:2], 2'b00};
  assign trap_target = (exc_handler_addr[1:0] == 2'b01 && exc_cause[31])
                     ? trap_base + {25'd0, exc_cause[4:0], 2'b00}
                     : trap_base;

  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    redirect_load = 1'b0;
    redirect_nxt  = trap_target;
    case (state)
      IDLE: begin
        if (trap_take) begin
          // A trap always wins over a coincident sret, which is dropped.
          capture   = 1'b1;
          state_nxt = COMMIT;
        end else if (sret) begin
          redirect_load = 1'b1;
          redirect_nxt  = exc_continue_addr;
          state_nxt     = REDIRECT;
        end
      end
      COMMIT: begin
        redirect_load = 1'b1;
        state_nxt     = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      exc_cause   <= 32'd0;
      exc_pc      <= 32'd0;
      exc_value   <= 32'd0;
      redirect_pc <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state <= state_nxt;
      if (capture) begin
        exc_cause <= trap_cause;
        exc_pc    <= trap_pc;
        exc_value <= trap_value;
      end
      if (redirect_load) redirect_pc <= redirect_nxt;
    end
  end

  assign exception      = (state == COMMIT);
  assign redirect_valid = (state == REDIRECT);
  assign flush          = (state == COMMIT) || (state == REDIRECT);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// Directed self-checking bench for cpu_trap_ctrl: a table of single-request
// vectors plus hand-written sequences for stall, back-to-back and reset cases.
module tb_cpu_trap_ctrl;

  localparam logic [31:0] RST_PC = 32'hDEAD_BEE0;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_fetch_misalign, exc_illegal, exc_ecall, exc_ebreak;
  logic        exc_ld_misalign, exc_st_misalign;
  logic [31:0] fetch_pc, inst_pc, inst_bits, mem_addr;
  logic        irq_timer, irq_ext, int_enable, inst_boundary, sret;
  logic [31:0] exc_handler_addr, exc_continue_addr;
  logic        exception, flush, redirect_valid, redirect_ready, busy;
  logic [31:0] exc_cause, exc_pc, exc_value, redirect_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_trap_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .exc_fetch_misalign(exc_fetch_misalign), .fetch_pc(fetch_pc),
    .exc_illegal(exc_illegal), .exc_ecall(exc_ecall), .exc_ebreak(exc_ebreak),
    .exc_ld_misalign(exc_ld_misalign), .exc_st_misalign(exc_st_misalign),
    .inst_pc(inst_pc), .inst_bits(inst_bits), .mem_addr(mem_addr),
    .irq_timer(irq_timer), .irq_ext(irq_ext), .int_enable(int_enable),
    .inst_boundary(inst_boundary), .sret(sret),
    .exc_handler_addr(exc_handler_addr), .exc_continue_addr(exc_continue_addr),
    .exception(exception), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_value(exc_value), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .busy(busy)
  );

  localparam logic [1:0] K_NONE = 2'd0, K_TRAP = 2'd1, K_SRET = 2'd2;

  typedef struct packed {
    logic        fm, ill, ecall, ebreak, ld, st, irq_t, irq_e, ie, ib, sr;
    logic [31:0] fetch_pc, inst_pc, inst_bits, mem_addr, stvec, sepc;
    logic [1:0]  kind;
    logic [31:0] cause, epc, eval, target;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  logic [31:0] last_cause, last_pc, last_value;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    exc_fetch_misalign = 0; exc_illegal = 0; exc_ecall = 0; exc_ebreak = 0;
    exc_ld_misalign = 0; exc_st_misalign = 0; irq_timer = 0; irq_ext = 0;
    sret = 0;
  endtask

  task automatic drive(input vec_t v);
    exc_fetch_misalign = v.fm; exc_illegal = v.ill; exc_ecall = v.ecall;
    exc_ebreak = v.ebreak; exc_ld_misalign = v.ld; exc_st_misalign = v.st;
    irq_timer = v.irq_t; irq_ext = v.irq_e; int_enable = v.ie;
    inst_boundary = v.ib; sret = v.sr;
    fetch_pc = v.fetch_pc; inst_pc = v.inst_pc; inst_bits = v.inst_bits;
    mem_addr = v.mem_addr; exc_handler_addr = v.stvec;
    exc_continue_addr = v.sepc;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_exception"}, {31'd0, exception}, 32'd0);
    check({tag, "_flush"}, {31'd0, flush}, 32'd0);
    check({tag, "_rvalid"}, {31'd0, redirect_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_cause"}, exc_cause, 32'd0);
    check({tag, "_pc"}, exc_pc, 32'd0);
    check({tag, "_value"}, exc_value, 32'd0);
    check({tag, "_rpc"}, redirect_pc, RST_PC);
  endtask

  initial begin
    vecs[0]  = '{ill:1, inst_pc:32'h100, inst_bits:32'hFFFF_FFFF, stvec:32'h8000_0000,
                 kind:K_TRAP, cause:2, epc:32'h100, eval:32'hFFFF_FFFF,
                 target:32'h8000_0000, default:'0};
    vecs[1]  = '{fm:1, ill:1, fetch_pc:32'h302, inst_pc:32'h100, stvec:32'h8000_0001,
                 kind:K_TRAP, cause:0, epc:32'h302, eval:32'h302,
                 target:32'h8000_0000, default:'0};
    vecs[2]  = '{ill:1, ecall:1, ld:1, inst_pc:32'h140, inst_bits:32'h0000_0013,
                 mem_addr:32'h55, stvec:32'h4000_0000, kind:K_TRAP, cause:2,
                 epc:32'h140, eval:32'h0000_0013, target:32'h4000_0000, default:'0};
    vecs[3]  = '{ebreak:1, ecall:1, inst_pc:32'h404, stvec:32'h4000_0000,
                 kind:K_TRAP, cause:3, epc:32'h404, eval:32'h404,
                 target:32'h4000_0000, default:'0};
    vecs[4]  = '{ecall:1, ld:1, inst_pc:32'h500, mem_addr:32'h99, stvec:32'h1000_0003,
                 kind:K_TRAP, cause:9, epc:32'h500, eval:0,
                 target:32'h1000_0000, default:'0};
    vecs[5]  = '{ld:1, st:1, inst_pc:32'h520, mem_addr:32'h123, stvec:32'h1000_0000,
                 kind:K_TRAP, cause:4, epc:32'h520, eval:32'h123,
                 target:32'h1000_0000, default:'0};
    vecs[6]  = '{st:1, inst_pc:32'h540, mem_addr:32'h777, stvec:32'h1000_0001,
                 kind:K_TRAP, cause:6, epc:32'h540, eval:32'h777,
                 target:32'h1000_0000, default:'0};
    vecs[7]  = '{irq_e:1, irq_t:1, ie:1, ib:1, inst_pc:32'h600, stvec:32'h8000_0001,
                 kind:K_TRAP, cause:32'h8000_0009, epc:32'h600, eval:0,
                 target:32'h8000_0024, default:'0};
    vecs[8]  = '{irq_t:1, ie:1, ib:1, inst_pc:32'h610, stvec:32'h8000_0001,
                 kind:K_TRAP, cause:32'h8000_0005, epc:32'h610, eval:0,
                 target:32'h8000_0014, default:'0};
    vecs[9]  = '{irq_e:1, irq_t:1, ie:0, ib:1, inst_pc:32'h620, stvec:32'h8000_0001,
                 kind:K_NONE, default:'0};
    vecs[10] = '{irq_e:1, ie:1, ib:0, inst_pc:32'h630, stvec:32'h8000_0001,
                 kind:K_NONE, default:'0};
    vecs[11] = '{irq_t:1, ie:1, ib:1, inst_pc:32'h640, stvec:32'h0000_0000,
                 kind:K_TRAP, cause:32'h8000_0005, epc:32'h640, eval:0,
                 target:32'h0000_0000, default:'0};
    vecs[12] = '{sr:1, inst_pc:32'h650, sepc:32'h200, stvec:32'h8000_0000,
                 kind:K_SRET, target:32'h200, default:'0};
    vecs[13] = '{sr:1, ecall:1, inst_pc:32'h700, sepc:32'h200, stvec:32'h8000_0000,
                 kind:K_TRAP, cause:9, epc:32'h700, eval:0,
                 target:32'h8000_0000, default:'0};
    vecs[14] = '{irq_t:1, ie:1, ib:1, inst_pc:32'h710, stvec:32'hFFFF_FFF1,
                 kind:K_TRAP, cause:32'h8000_0005, epc:32'h710, eval:0,
                 target:32'h0000_0004, default:'0};
    vecs[15] = '{ill:1, irq_e:1, ie:1, ib:1, inst_pc:32'h720, inst_bits:32'hABCD_0001,
                 stvec:32'h8000_0001, kind:K_TRAP, cause:2, epc:32'h720,
                 eval:32'hABCD_0001, target:32'h8000_0000, default:'0};

    // Reset state
    rst = 1; redirect_ready = 1;
    clear_req();
    drive('0);
    #2;
    check_reset_state("reset");
    #6 rst = 0;
    step();
    last_cause = 0; last_pc = 0; last_value = 0;

    // Table-driven single requests from IDLE, redirect_ready held high
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      step();
      clear_req();
      case (vecs[i].kind)
        K_TRAP: begin
          check($sformatf("v%0d_exception", i), {31'd0, exception}, 32'd1);
          check($sformatf("v%0d_flush_c", i), {31'd0, flush}, 32'd1);
          check($sformatf("v%0d_cause", i), exc_cause, vecs[i].cause);
          check($sformatf("v%0d_epc", i), exc_pc, vecs[i].epc);
          check($sformatf("v%0d_eval", i), exc_value, vecs[i].eval);
          last_cause = vecs[i].cause; last_pc = vecs[i].epc; last_value = vecs[i].eval;
          step();
          check($sformatf("v%0d_pulse_end", i), {31'd0, exception}, 32'd0);
          check($sformatf("v%0d_rvalid", i), {31'd0, redirect_valid}, 32'd1);
          check($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].target);
          check($sformatf("v%0d_flush_r", i), {31'd0, flush}, 32'd1);
          step();
          check($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
        end
        K_SRET: begin
          check($sformatf("v%0d_exception", i), {31'd0, exception}, 32'd0);
          check($sformatf("v%0d_rvalid", i), {31'd0, redirect_valid}, 32'd1);
          check($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].target);
          check($sformatf("v%0d_cause_held", i), exc_cause, last_cause);
          step();
          check($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
        end
        default: begin
          check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
          check($sformatf("v%0d_exception", i), {31'd0, exception}, 32'd0);
          check($sformatf("v%0d_cause_held", i), exc_cause, last_cause);
          check($sformatf("v%0d_epc_held", i), exc_pc, last_pc);
        end
      endcase
    end

    // Stall: redirect_ready low, new requests during REDIRECT are ignored
    redirect_ready = 0;
    exc_ecall = 1; inst_pc = 32'h900; exc_handler_addr = 32'h3000_0000;
    step();
    clear_req();
    check("stall_exception", {31'd0, exception}, 32'd1);
    step();
    for (int c = 0; c < 5; c++) begin
      exc_ecall = 1; exc_illegal = 1; inst_pc = 32'hA00 + c;
      exc_handler_addr = 32'h5000_0000;
      check($sformatf("stall%0d_rvalid", c), {31'd0, redirect_valid}, 32'd1);
      check($sformatf("stall%0d_rpc", c), redirect_pc, 32'h3000_0000);
      check($sformatf("stall%0d_flush", c), {31'd0, flush}, 32'd1);
      check($sformatf("stall%0d_exception", c), {31'd0, exception}, 32'd0);
      check($sformatf("stall%0d_cause", c), exc_cause, 32'd9);
      check($sformatf("stall%0d_epc", c), exc_pc, 32'h900);
      step();
    end
    clear_req();
    redirect_ready = 1;
    check("stall_last_rvalid", {31'd0, redirect_valid}, 32'd1);
    step();
    check("stall_idle", {31'd0, busy}, 32'd0);
    step();
    check("stall_not_queued", {31'd0, busy}, 32'd0);

    // Back-to-back: a held request still leaves one IDLE cycle between traps
    exc_illegal = 1; inst_pc = 32'hB00; inst_bits = 32'h1234_5678;
    exc_handler_addr = 32'h8000_0000;
    step();
    check("b2b_exc1", {31'd0, exception}, 32'd1);
    step();
    check("b2b_redirect1", {31'd0, redirect_valid}, 32'd1);
    step();
    check("b2b_idle_gap", {31'd0, busy}, 32'd0);
    step();
    check("b2b_exc2", {31'd0, exception}, 32'd1);
    clear_req();
    step();
    step();
    check("b2b_done", {31'd0, busy}, 32'd0);

    // Reset in the middle of COMMIT drops the trap
    exc_ecall = 1; inst_pc = 32'hC00;
    step();
    clear_req();
    check("rstc_in_commit", {31'd0, exception}, 32'd1);
    #2 rst = 1;
    #1 check_reset_state("rstc");
    #1 rst = 0;
    step();
    check("rstc_no_redirect", {31'd0, redirect_valid}, 32'd0);

    // Reset in the middle of a stalled REDIRECT
    redirect_ready = 0;
    exc_ecall = 1; inst_pc = 32'hD00;
    step();
    clear_req();
    step();
    check("rstr_in_redirect", {31'd0, redirect_valid}, 32'd1);
    #2 rst = 1;
    #1 check_reset_state("rstr");
    #1 rst = 0;
    redirect_ready = 1;
    step();
    check("rstr_stays_idle", {31'd0, busy}, 32'd0);
    exc_illegal = 1; inst_pc = 32'hE00; inst_bits = 32'hFFFF_0000;
    exc_handler_addr = 32'h8000_0100;
    step();
    clear_req();
    check("rstr_fresh_exc", {31'd0, exception}, 32'd1);
    check("rstr_fresh_cause", exc_cause, 32'd2);
    check("rstr_fresh_value", exc_value, 32'hFFFF_0000);
    step();
    check("rstr_fresh_rpc", redirect_pc, 32'h8000_0100);
    step();
    check("rstr_fresh_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
